// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the chunked serial adder.
package adder_pkg;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   // Chunk-index width; a single-chunk adder still gets a 1-bit index.
   function automatic int unsigned idx_width(input int unsigned m);
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/chunk_add.sv
// Combinational K-bit ripple adder built from full_adder cells.
module chunk_add #(
   parameter int unsigned K = 4
) (
   input  logic [K-1:0] a,
   input  logic [K-1:0] b,
   input  logic         ci,
   output logic [K-1:0] s,
   output logic         co
);

   logic [K:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < K; i++) begin : g_bit
      full_adder u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .ci (c[i]),
         .s  (s[i]),
         .co (c[i+1])
      );
   end

   assign co = c[K];

endmodule

// File: rtl/full_adder.sv
// 1-bit full adder cell used to build the chunk adder.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle N-bit adder processing K bits per clock with a registered carry.
// Optional subtract mode enabled by defining CHUNKED_ADDER_SUB_EN.
module chunked_serial_adder
   import adder_pkg::*;
#(
   parameter int unsigned N = 16,
   parameter int unsigned K = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         cin,
`ifdef CHUNKED_ADDER_SUB_EN
   input  logic         sub,
`endif
   output logic         busy,
   output logic         done,
   output logic [N-1:0] Sum,
   output logic         Cout
);

   localparam int unsigned M  = (K == 0) ? 1 : N / K;
   localparam int unsigned IW = idx_width(M);
   localparam logic [IW-1:0] LAST = IW'(M - 1);

   if (N < 1 || K < 1 || (N % K) != 0) begin : g_bad_params
      $fatal(1, "chunked_serial_adder: N must be >= 1, K >= 1 and N %% K == 0");
   end

   state_t        state;
   logic [IW-1:0] idx;
   logic [N-1:0]  a_r;
   logic [N-1:0]  b_r;
   logic          carry_r;

   logic [K-1:0]  a_chunk;
   logic [K-1:0]  b_chunk;
   logic [K-1:0]  s_chunk;
   logic          c_chunk;

   assign a_chunk = a_r[idx*K +: K];
   assign b_chunk = b_r[idx*K +: K];

   chunk_add #(.K(K)) u_chunk_add (
      .a  (a_chunk),
      .b  (b_chunk),
      .ci (carry_r),
      .s  (s_chunk),
      .co (c_chunk)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         idx     <= '0;
         a_r     <= '0;
         b_r     <= '0;
         carry_r <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         Sum     <= '0;
         Cout    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= RUN;
                  busy  <= 1'b1;
                  idx   <= '0;
                  a_r   <= A;
                  Sum   <= '0;
                  Cout  <= 1'b0;
`ifdef CHUNKED_ADDER_SUB_EN
                  // Subtract stores ~B so the shared chunk adder sees A + ~B + 1.
                  b_r     <= sub ? ~B : B;
                  carry_r <= sub | cin;
`else
                  b_r     <= B;
                  carry_r <= cin;
`endif
               end
            end
            RUN: begin
               Sum[idx*K +: K] <= s_chunk;
               carry_r         <= c_chunk;
               if (idx == LAST) begin
                  Cout  <= c_chunk;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  idx   <= '0;
                  state <= IDLE;
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Self-checking bench for chunked_serial_adder at N=8, K=2 against an arithmetic model.
module tb_chunked_serial_adder;

   localparam int unsigned N = 8;
   localparam int unsigned K = 2;
   localparam int unsigned M = N / K;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic         cin;
`ifdef CHUNKED_ADDER_SUB_EN
   logic         sub;
`endif
   logic         busy;
   logic         done;
   logic [N-1:0] Sum;
   logic         Cout;

   int vectors    = 0;
   int miscompares = 0;

   chunked_serial_adder #(.N(N), .K(K)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
      .cin   (cin),
`ifdef CHUNKED_ADDER_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .Sum   (Sum),
      .Cout  (Cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Exact (N+1)-bit result from plain arithmetic.
   function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                        input logic c, input logic s);
      int unsigned r;
      if (s) r = int'(a) + (255 - int'(b)) + 1;
      else   r = int'(a) + int'(b) + int'(c);
      return r[N:0];
   endfunction

   // Present an operation before the next rising edge, then wait for done.
   // cyc counts edges after the accepting edge up to the one raising done.
   task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                         input logic s, output int cyc);
      A = a; B = b; cin = c; start = 1'b1;
`ifdef CHUNKED_ADDER_SUB_EN
      sub = s;
`else
      if (s) $display("note: sub requested without subtract build");
`endif
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (!done && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset;
      vectors++;
      if ({busy, done, Sum, Cout} !== '0) begin
         miscompares++;
         $display("FAIL reset_hold: got busy=%b done=%b Sum=%h Cout=%b, want all 0", busy, done, Sum, Cout);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if ({busy, done, Sum, Cout} !== '0) begin
         miscompares++;
         $display("FAIL reset_release: got busy=%b done=%b Sum=%h Cout=%b, want all 0", busy, done, Sum, Cout);
      end
   endtask

   task automatic test_ripple;
      int cyc;
      run_op(8'hFF, 8'h01, 1'b0, 1'b0, cyc);
      vectors++;
      if (cyc !== M) begin
         miscompares++;
         $display("FAIL ripple_latency: got %0d cycles, want %0d", cyc, M);
      end
      vectors++;
      if ({Cout, Sum} !== 9'h100) begin
         miscompares++;
         $display("FAIL ripple_result: got Cout=%b Sum=%h, want Cout=1 Sum=00", Cout, Sum);
      end
   endtask

   task automatic test_cin_only;
      int busy_cycles = 0;
      A = 8'h00; B = 8'h00; cin = 1'b1; start = 1'b1;
`ifdef CHUNKED_ADDER_SUB_EN
      sub = 1'b0;
`endif
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < int'(M); i++) begin
         if (busy === 1'b1 && done === 1'b0) busy_cycles++;
         @(negedge clk);
      end
      vectors++;
      if (busy_cycles !== M) begin
         miscompares++;
         $display("FAIL cin_busy_width: got %0d busy cycles, want %0d", busy_cycles, M);
      end
      vectors++;
      if ({busy, done} !== 2'b01) begin
         miscompares++;
         $display("FAIL cin_done_edge: got busy=%b done=%b, want busy=0 done=1", busy, done);
      end
      vectors++;
      if ({Cout, Sum} !== 9'h001) begin
         miscompares++;
         $display("FAIL cin_result: got Cout=%b Sum=%h, want Cout=0 Sum=01", Cout, Sum);
      end
   endtask

   task automatic test_start_while_busy;
      int dones = 0;
      int first = -1;
      A = 8'h12; B = 8'h34; cin = 1'b0; start = 1'b1;
`ifdef CHUNKED_ADDER_SUB_EN
      sub = 1'b0;
`endif
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      A = 8'hAA; B = 8'hAA; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 3; i <= 10; i++) begin
         @(negedge clk);
         if (done) begin
            dones++;
            if (first < 0) first = i;
            vectors++;
            if ({Cout, Sum} !== 9'h046) begin
               miscompares++;
               $display("FAIL busy_ignore_result: got Cout=%b Sum=%h, want Cout=0 Sum=46", Cout, Sum);
            end
         end
      end
      vectors++;
      if (dones !== 1 || first !== int'(M)) begin
         miscompares++;
         $display("FAIL busy_ignore_dones: got %0d dones first at %0d, want 1 at %0d", dones, first, M);
      end
   endtask

   task automatic test_back_to_back;
      int cyc;
      run_op(8'h12, 8'h34, 1'b0, 1'b0, cyc);
      vectors++;
      if ({done, Cout, Sum} !== 10'h246) begin
         miscompares++;
         $display("FAIL b2b_first: got done=%b Cout=%b Sum=%h, want done=1 Cout=0 Sum=46", done, Cout, Sum);
      end
      run_op(8'h80, 8'h80, 1'b0, 1'b0, cyc);
      vectors++;
      if (cyc !== M) begin
         miscompares++;
         $display("FAIL b2b_latency: got %0d cycles, want %0d", cyc, M);
      end
      vectors++;
      if ({Cout, Sum} !== 9'h100) begin
         miscompares++;
         $display("FAIL b2b_second: got Cout=%b Sum=%h, want Cout=1 Sum=00", Cout, Sum);
      end
   endtask

   task automatic test_reset_mid_op;
      int cyc;
      int dones = 0;
      A = 8'hFF; B = 8'hFF; cin = 1'b1; start = 1'b1;
`ifdef CHUNKED_ADDER_SUB_EN
      sub = 1'b0;
`endif
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      vectors++;
      if ({busy, done, Sum, Cout} !== '0) begin
         miscompares++;
         $display("FAIL reset_mid_outputs: got busy=%b done=%b Sum=%h Cout=%b, want all 0", busy, done, Sum, Cout);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done) dones++;
      end
      vectors++;
      if (dones !== 0) begin
         miscompares++;
         $display("FAIL reset_mid_no_done: got %0d dones, want 0", dones);
      end
      run_op(8'h05, 8'h03, 1'b0, 1'b0, cyc);
      vectors++;
      if ({Cout, Sum} !== 9'h008 || cyc !== M) begin
         miscompares++;
         $display("FAIL reset_mid_after: got Cout=%b Sum=%h in %0d cycles, want Sum=08 in %0d", Cout, Sum, cyc, M);
      end
   endtask

   task automatic test_random;
      int cyc;
      logic [N:0] exp_prev;
      for (int i = 0; i < 40; i++) begin
         logic [N-1:0] a = N'($urandom);
         logic [N-1:0] b = N'($urandom);
         logic c = 1'($urandom);
         logic s = 1'b0;
         logic [N:0] exp;
`ifdef CHUNKED_ADDER_SUB_EN
         s = 1'($urandom);
`endif
         if (i > 0) begin
            int gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
               A = N'($urandom); B = N'($urandom); cin = 1'($urandom);
               @(negedge clk);
               vectors++;
               if ({Cout, Sum} !== exp_prev) begin
                  miscompares++;
                  $display("FAIL rand_hold: got %h, want %h", {Cout, Sum}, exp_prev);
               end
            end
         end
         exp = model(a, b, c, s);
         A = a; B = b; cin = c; start = 1'b1;
`ifdef CHUNKED_ADDER_SUB_EN
         sub = s;
`endif
         @(negedge clk);
         start = 1'b0;
         cyc = 0;
         while (!done && cyc < 20) begin
            A = N'($urandom); B = N'($urandom); cin = 1'($urandom);
            if ($urandom_range(0, 1) == 1) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            cyc++;
         end
         vectors++;
         if ({Cout, Sum} !== exp || cyc !== M) begin
            miscompares++;
            $display("FAIL rand_op %0d: a=%h b=%h c=%b s=%b got %h in %0d cycles, want %h in %0d",
                     i, a, b, c, s, {Cout, Sum}, cyc, exp, M);
         end
         exp_prev = exp;
      end
   endtask

`ifdef CHUNKED_ADDER_SUB_EN
   task automatic test_subtract;
      int cyc;
      run_op(8'h05, 8'h07, 1'b0, 1'b1, cyc);
      vectors++;
      if ({Cout, Sum} !== 9'h0FE) begin
         miscompares++;
         $display("FAIL sub_borrow: got Cout=%b Sum=%h, want Cout=0 Sum=FE", Cout, Sum);
      end
      @(negedge clk);
      run_op(8'h07, 8'h05, 1'b0, 1'b1, cyc);
      vectors++;
      if ({Cout, Sum} !== 9'h102) begin
         miscompares++;
         $display("FAIL sub_no_borrow: got Cout=%b Sum=%h, want Cout=1 Sum=02", Cout, Sum);
      end
      @(negedge clk);
   endtask
`endif

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      A = '0; B = '0; cin = 1'b0;
`ifdef CHUNKED_ADDER_SUB_EN
      sub = 1'b0;
`endif
      @(negedge clk);
      @(negedge clk);
      test_reset;
      test_ripple;
      @(negedge clk);
      test_cin_only;
      @(negedge clk);
      test_start_while_busy;
      @(negedge clk);
      test_back_to_back;
      @(negedge clk);
      test_reset_mid_op;
      @(negedge clk);
`ifdef CHUNKED_ADDER_SUB_EN
      test_subtract;
`endif
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
